div_arbiter: RTL and testbench
==============================

# div_arbiter

Two-port arbiter and sequencer that shares one 16-bit divider core between two independent requesters. Each requester posts a dividend/divisor pair with a level request; the block grants the core round-robin, pulses the core's init, waits for done, and returns the quotient with a one-cycle ack. It sits between the bus-side register logic of the divider peripheral and the divider core, and adds divide-by-zero screening and a done timeout.

## Interface
- WIDTH, 16, operand and quotient width
- TIMEOUT, 255, maximum WAIT cycles before abort (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 request, level, held until ack0
- a0  in  WIDTH  requester 0 dividend
- b0  in  WIDTH  requester 0 divisor
- ack0  out  1  one-cycle completion pulse to requester 0
- q0  out  WIDTH  requester 0 quotient, registered, held until next ack0
- err0  out  1  requester 0 error flag, registered, held until next ack0
- req1, a1, b1, ack1, q1, err1: same as port 0, for requester 1
- div_a  out  WIDTH  operand A to core
- div_b  out  WIDTH  operand B to core
- div_init  out  1  core start pulse
- div_done  in  1  core completion, sampled only in WAIT
- div_q  in  WIDTH  core quotient, valid with div_done
- busy  out  1  high when state ≠ IDLE
- grant  out  1  index of current/last granted requester

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. All outputs registered except busy (decoded from state).
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port ≠ last-served; last-served resets to 1, so port 0 wins first contention. On grant: latch a/b into div_a/div_b, set grant.
- Divisor zero at grant: skip core, go to RESP with q=all ones, err=1; div_init is never asserted.
- Otherwise go to LAUNCH: div_init=1 for exactly this one cycle; div_a/div_b stable from LAUNCH through RESP.
- WAIT: cycle counter cleared on entry. div_done=1 → capture div_q, err=0, go to RESP. No done after TIMEOUT WAIT cycles → q=all ones, err=1, go to RESP. Done in the last allowed cycle wins over timeout.
- RESP: ackN=1 for granted port only, qN/errN updated at entry to RESP; update last-served; go to IDLE. The other port's q/err/ack are untouched.
- Requester rule: req must be low when IDLE next samples it (cycle after ack). Operands must be stable from req rise until ack.
- div_done outside WAIT is ignored.
- Reset (async, rst low): state IDLE, last-served=1, counter 0; ack0/ack1/div_init/err0/err1/busy/grant=0; q0/q1/div_a/div_b=0. Reset mid-operation abandons the transaction with no ack.

## Timing
- Cycle n: IDLE samples req high at end of n.
- n+1: LAUNCH, div_init=1, busy=1.
- n+2 onward: WAIT. div_done high in cycle m → RESP in m+1 with ack=1, q valid in m+1.
- m+2: IDLE, busy=0; new request sampled at end of m+2. Minimum back-to-back issue spacing: 4 cycles plus core latency.
- Divide-by-zero: RESP in n+1, ack in n+1.
- Timeout: WAIT occupies cycles n+2 … n+1+TIMEOUT; RESP in n+2+TIMEOUT.
- grant valid from n+1 and held through IDLE until next grant.

## Test plan
- Single request: req0, a0=10, b0=4; core model asserts div_done with div_q=2 five cycles after div_init → div_init single pulse in n+1 with div_a=10, div_b=4; ack0 one pulse with q0=2, err0=0; ack1 never asserted; busy low after.
- Contention: after reset, req0 (100/7) and req1 (50/5) both held continuously for 4 transactions → grant order 0,1,0,1; q0=14, q1=10; each ack tied to correct port.
- Divide by zero: req1, a1=35, b1=0 → ack1 in cycle after sampling, q1=16'hFFFF, err1=1; div_init never high; q0/err0 unchanged.
- Timeout: TIMEOUT=8, core never asserts done → ack0 exactly in cycle n+10 with q0=16'hFFFF, err0=1; following request with normal core completes with err0=0.
- Done at limit: TIMEOUT=8, div_done in 8th WAIT cycle with div_q=3 → ack0, q0=3, err0=0.
- Async reset in WAIT: drop rst mid-cycle → all outputs 0 immediately, no ack; after release, req1 alone (9/3, div_q=3) served normally with q1=3.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one divider core between two requesters,
// with divide-by-zero screening and a bounded wait for core completion.
module div_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    output logic [WIDTH-1:0] q0,
    output logic             err0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic [WIDTH-1:0] q1,
    output logic             err1,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_init,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    output logic             busy,
    output logic             grant
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic             r_last;
    logic             r_grant;
    logic [CW-1:0]    r_cnt;

    logic             w_sel;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_fin;
    logic             w_fin_port;
    logic [WIDTH-1:0] w_fin_q;
    logic             w_fin_err;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_sel      = (req0 && req1) ? ~r_last : req1;
        w_a        = w_sel ? a1 : a0;
        w_b        = w_sel ? b1 : b0;
        w_fin      = 1'b0;
        w_fin_q    = '1;
        w_fin_err  = 1'b1;
        w_fin_port = (r_state == S_IDLE) ? w_sel : r_grant;
        case (r_state)
            S_IDLE: w_fin = (req0 || req1) && (w_b == '0);
            S_WAIT: begin
                // Done in the last allowed cycle takes priority over the timeout.
                if (div_done) begin
                    w_fin     = 1'b1;
                    w_fin_q   = div_q;
                    w_fin_err = 1'b0;
                end else begin
                    w_fin = (r_cnt == LAST_WAIT);
                end
            end
            default: ;
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign grant = r_grant;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_grant  <= 1'b0;
            r_cnt    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            q0       <= '0;
            q1       <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            div_a    <= '0;
            div_b    <= '0;
            div_init <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            div_init <= 1'b0;
            if (w_fin) begin
                if (w_fin_port) begin
                    ack1 <= 1'b1;
                    q1   <= w_fin_q;
                    err1 <= w_fin_err;
                end else begin
                    ack0 <= 1'b1;
                    q0   <= w_fin_q;
                    err0 <= w_fin_err;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_grant <= w_sel;
                        div_a   <= w_a;
                        div_b   <= w_b;
                        if (w_b == '0) begin
                            r_state <= S_RESP;
                        end else begin
                            div_init <= 1'b1;
                            r_state  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_fin) r_state <= S_RESP;
                    else       r_cnt   <= r_cnt + 1'b1;
                end
                S_RESP: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: table vectors, hand-written corner sequences and randomized
// transactions, all checked against a transaction-level model of the arbiter.
module tb_div_arbiter;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, err0, err1;
    logic [W-1:0] q0, q1, div_a, div_b, div_q;
    logic         div_init, div_done, busy, grant;

    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    assign a0 = op_a[0];
    assign b0 = op_b[0];
    assign a1 = op_a[1];
    assign b1 = op_b[1];

    div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .q0(q0), .err0(err0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .q1(q1), .err1(err1),
        .div_a(div_a), .div_b(div_b), .div_init(div_init),
        .div_done(div_done), .div_q(div_q), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Behavioural core: done 'core_lat' cycles after the init cycle, never when 0.
    int   core_lat = 0;
    int   core_cnt;
    logic spur = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst)              core_cnt <= 0;
        else if (div_init)     core_cnt <= core_lat;
        else if (core_cnt > 0) core_cnt <= core_cnt - 1;
    end
    assign div_done = (core_cnt == 1) || spur;
    assign div_q    = (div_b != '0) ? div_a / div_b : '1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model state.
    logic         last_m;
    logic [W-1:0] exp_q [2];
    logic         exp_err [2];

    function automatic bit done_in_time(int lat);
        return (lat >= 1) && (lat <= TO);
    endfunction

    // Cycles from the IDLE sampling cycle to the ack cycle.
    function automatic int exp_t(int p, int lat);
        if (op_b[p] == '0)     return 1;
        if (done_in_time(lat)) return lat + 2;
        return TO + 2;
    endfunction

    task automatic model_reset();
        last_m     = 1'b1;
        exp_q[0]   = '0;
        exp_q[1]   = '0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Raise the requests in 'mask' and follow every resulting transaction to its ack.
    task automatic serve(input logic [1:0] mask, input int lat);
        int order[$];
        int t, s, due, cur, inits, exp_inits;
        if (mask == 2'b11) begin
            order.push_back(last_m ? 0 : 1);
            order.push_back(last_m ? 1 : 0);
        end else begin
            order.push_back(mask[1] ? 1 : 0);
        end
        exp_inits = 0;
        foreach (order[i]) if (op_b[order[i]] != '0) exp_inits++;
        core_lat = lat;
        req0 = mask[0];
        req1 = mask[1];
        t = 0; s = 0; inits = 0;
        due = exp_t(order[0], lat);
        while (order.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
            cur = order[0];
            if (t == s + 1) check("busy_run", busy, 1);
            if (div_init) begin
                inits++;
                check("init_cycle", t, s + 1);
                check("div_a", div_a, op_a[cur]);
                check("div_b", div_b, op_b[cur]);
            end
            if (ack0 || ack1) begin
                check("ack_port", {ack1, ack0}, cur ? 2'b10 : 2'b01);
                check("ack_time", t, due);
                check("grant", grant, cur);
                if (op_b[cur] == '0 || !done_in_time(lat)) begin
                    exp_q[cur]   = '1;
                    exp_err[cur] = 1'b1;
                end else begin
                    exp_q[cur]   = op_a[cur] / op_b[cur];
                    exp_err[cur] = 1'b0;
                end
                last_m = cur[0];
                check("q0", q0, exp_q[0]);
                check("err0", err0, exp_err[0]);
                check("q1", q1, exp_q[1]);
                check("err1", err1, exp_err[1]);
                if (cur == 1) req1 = 1'b0;
                else          req0 = 1'b0;
                void'(order.pop_front());
                if (order.size() > 0) begin
                    s   = t + 1;
                    due = s + exp_t(order[0], lat);
                end
            end
        end
        if (order.size() > 0) begin
            check("ack_bound", 0, 1);
            req0 = 1'b0;
            req1 = 1'b0;
        end
        check("init_count", inits, exp_inits);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("ack_after", {ack1, ack0}, 2'b00);
    endtask

    typedef struct {
        logic [1:0]   mask;
        logic [W-1:0] a0, b0, a1, b1;
        int           lat;
        logic [W-1:0] q0;
        logic         err0;
        logic [W-1:0] q1;
        logic         err1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'b01,  10,  4,  0, 0, 5,      2, 1'b0,      0, 1'b0}; // single request
        vecs[1] = '{2'b10,   0,  0, 35, 0, 5,      2, 1'b0, 'hFFFF, 1'b1}; // divide by zero
        vecs[2] = '{2'b01,  10,  4,  0, 0, 0, 'hFFFF, 1'b1, 'hFFFF, 1'b1}; // timeout
        vecs[3] = '{2'b01,  20,  5,  0, 0, 3,      4, 1'b0, 'hFFFF, 1'b1}; // recovery
        vecs[4] = '{2'b01,   9,  3,  0, 0, TO,     3, 1'b0, 'hFFFF, 1'b1}; // done at limit
        vecs[5] = '{2'b10,   0,  0,  7, 2, TO + 1, 3, 1'b0, 'hFFFF, 1'b1}; // done one too late
        vecs[6] = '{2'b11, 100,  7, 50, 5, 4,     14, 1'b0,     10, 1'b0}; // contention

        op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;
        model_reset();
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_flags", {ack0, ack1, err0, err1, div_init, grant}, 6'b0);
        check("rst_q0", q0, 0);
        check("rst_q1", q1, 0);
        check("rst_div_ab", {div_a, div_b}, 32'h0);

        foreach (vecs[i]) begin
            op_a[0] = vecs[i].a0; op_b[0] = vecs[i].b0;
            op_a[1] = vecs[i].a1; op_b[1] = vecs[i].b1;
            serve(vecs[i].mask, vecs[i].lat);
            check("vec_q0", q0, vecs[i].q0);
            check("vec_err0", err0, vecs[i].err0);
            check("vec_q1", q1, vecs[i].q1);
            check("vec_err1", err1, vecs[i].err1);
        end

        // Contention right after reset: grant order 0,1,0,1.
        do_reset();
        op_a[0] = 100; op_b[0] = 7; op_a[1] = 50; op_b[1] = 5;
        repeat (2) serve(2'b11, 5);
        check("cont_q0", q0, 14);
        check("cont_q1", q1, 10);

        // A stray done while idle must not start or finish anything.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur_busy", busy, 0);
        check("spur_ack", {ack1, ack0}, 2'b00);

        // Asynchronous reset in the middle of WAIT abandons the transaction.
        op_a[0] = 10; op_b[0] = 4; core_lat = 0; req0 = 1'b1;
        repeat (4) @(negedge clk);
        check("wait_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_flags", {ack0, ack1, err0, err1, div_init, grant}, 6'b0);
        check("arst_q", {q0, q1}, 32'h0);
        check("arst_div_ab", {div_a, div_b}, 32'h0);
        req0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_ack", {ack1, ack0}, 2'b00);
        end
        rst = 1'b1;
        model_reset();
        op_a[1] = 9; op_b[1] = 3;
        serve(2'b10, 3);
        check("arst_q1", q1, 3);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                op_a[p] = W'($urandom);
                op_b[p] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 300));
            end
            serve(m, $urandom_range(0, TO + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
